// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake and data bundle for bin_to_bcd_seq.
// master drives start/bin; slave returns status and result.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional macro BCD_SAT_EN: saturate bcd to all nines on overflow.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            reset_p,
  bin_to_bcd_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
`ifdef BCD_SAT_EN
  localparam logic [BW-1:0] ALL9 = {DIGITS{4'h9}};
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BIN_W-1:0] sr_q, sr_d;
  logic [BW-1:0]    wk_q, wk_d, wk_adj;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  // One shared set of +3 adjusters, applied to every digit in parallel
  always_comb begin
    wk_adj = wk_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (wk_q[4*i +: 4] > 4'd4)
        wk_adj[4*i +: 4] = wk_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    wk_d       = wk_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sr_d    = bus.bin;
          wk_d    = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        wk_d  = {wk_adj[BW-2:0], sr_q[BIN_W-1]};
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
        ovf_d = ovf_q | wk_adj[BW-1];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1))
          state_d = DONE;
      end
      DONE: begin
`ifdef BCD_SAT_EN
        bcd_d = ovf_q ? ALL9 : wk_q;
`else
        bcd_d = wk_q;
`endif
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      wk_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      wk_q       <= wk_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy     = (state_q == SHIFT);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: 12/4 default and 14/4 overflow instances.
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic reset_p = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.BIN_W(12), .DIGITS(4)) a_if ();
  bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(4)) b_if ();

  bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut_a (
    .clk(clk), .reset_p(reset_p), .bus(a_if)
  );
  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_b (
    .clk(clk), .reset_p(reset_p), .bus(b_if)
  );

  task automatic convert_a(input logic [11:0] v, output logic [15:0] b,
                           output logic o, output int lat);
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.bin   = v;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    a_if.bin   = ~v;
    lat = 0;
    while (!a_if.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    b = a_if.bcd;
    o = a_if.overflow;
  endtask

  task automatic convert_b(input logic [13:0] v, output logic [15:0] b,
                           output logic o, output int lat);
    @(negedge clk);
    b_if.start = 1'b1;
    b_if.bin   = v;
    @(posedge clk); #1;
    b_if.start = 1'b0;
    b_if.bin   = ~v;
    lat = 0;
    while (!b_if.done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    b = b_if.bcd;
    o = b_if.overflow;
  endtask

  task automatic test_reset();
    reset_p = 1'b1;
    #12;
    checks++;
    if ({a_if.busy, a_if.done, a_if.overflow} !== 3'b000 || a_if.bcd !== 16'h0) begin
      errors++;
      $display("FAIL reset_a busy=%b done=%b ovf=%b bcd=%h want 0", a_if.busy,
               a_if.done, a_if.overflow, a_if.bcd);
    end
    checks++;
    if ({b_if.busy, b_if.done, b_if.overflow} !== 3'b000 || b_if.bcd !== 16'h0) begin
      errors++;
      $display("FAIL reset_b busy=%b done=%b ovf=%b bcd=%h want 0", b_if.busy,
               b_if.done, b_if.overflow, b_if.bcd);
    end
    @(negedge clk);
    reset_p = 1'b0;
  endtask

  task automatic test_timing();
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.bin   = 12'd4095;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (a_if.busy !== 1'b1 || a_if.done !== 1'b0) begin
        errors++;
        $display("FAIL timing_busy k=%0d busy=%b done=%b want 1/0", k, a_if.busy, a_if.done);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (a_if.busy !== 1'b0 || a_if.done !== 1'b0) begin
      errors++;
      $display("FAIL timing_donestate busy=%b done=%b want 0/0", a_if.busy, a_if.done);
    end
    @(posedge clk); #1;
    checks++;
    if (a_if.done !== 1'b1 || a_if.bcd !== 16'h4095 || a_if.overflow !== 1'b0) begin
      errors++;
      $display("FAIL timing_4095 done=%b bcd=%h ovf=%b want 1/4095/0", a_if.done,
               a_if.bcd, a_if.overflow);
    end
    @(posedge clk); #1;
    checks++;
    if (a_if.done !== 1'b0 || a_if.bcd !== 16'h4095) begin
      errors++;
      $display("FAIL timing_pulse done=%b bcd=%h want 0/4095", a_if.done, a_if.bcd);
    end
  endtask

  task automatic test_values();
    logic [15:0] b;
    logic o;
    int lat;
    convert_a(12'd0, b, o, lat);
    checks++;
    if (b !== 16'h0000 || o !== 1'b0 || lat != 13) begin
      errors++;
      $display("FAIL conv_0 bcd=%h ovf=%b lat=%0d want 0000/0/13", b, o, lat);
    end
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.bin   = 12'd1234;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (a_if.bcd !== 16'h0000) begin
      errors++;
      $display("FAIL hold_prev bcd=%h want 0000", a_if.bcd);
    end
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (a_if.done !== 1'b1 || a_if.bcd !== 16'h1234) begin
      errors++;
      $display("FAIL conv_1234 done=%b bcd=%h want 1/1234", a_if.done, a_if.bcd);
    end
    convert_a(12'd809, b, o, lat);
    checks++;
    if (b !== 16'h0809 || o !== 1'b0 || lat != 13) begin
      errors++;
      $display("FAIL conv_809 bcd=%h ovf=%b lat=%0d want 0809/0/13", b, o, lat);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] b;
    logic o;
    int lat;
    logic [15:0] e10k;
    logic [15:0] emax;
`ifdef BCD_SAT_EN
    e10k = 16'h9999;
    emax = 16'h9999;
`else
    e10k = 16'h0000;
    emax = 16'h6383;
`endif
    convert_b(14'd9999, b, o, lat);
    checks++;
    if (b !== 16'h9999 || o !== 1'b0 || lat != 15) begin
      errors++;
      $display("FAIL w14_9999 bcd=%h ovf=%b lat=%0d want 9999/0/15", b, o, lat);
    end
    convert_b(14'd10000, b, o, lat);
    checks++;
    if (b !== e10k || o !== 1'b1) begin
      errors++;
      $display("FAIL w14_10000 bcd=%h ovf=%b want %h/1", b, o, e10k);
    end
    convert_b(14'd16383, b, o, lat);
    checks++;
    if (b !== emax || o !== 1'b1) begin
      errors++;
      $display("FAIL w14_16383 bcd=%h ovf=%b want %h/1", b, o, emax);
    end
    convert_b(14'd42, b, o, lat);
    checks++;
    if (b !== 16'h0042 || o !== 1'b0) begin
      errors++;
      $display("FAIL w14_42 bcd=%h ovf=%b want 0042/0", b, o);
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.bin   = 12'd255;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    dones = 0;
    for (int k = 1; k <= 34; k++) begin
      if (k == 3 || k == 13) begin
        a_if.start = 1'b1;
        a_if.bin   = 12'd7;
      end
      @(posedge clk); #1;
      a_if.start = 1'b0;
      if (a_if.done) begin
        dones++;
        checks++;
        if (k != 13 || a_if.bcd !== 16'h0255) begin
          errors++;
          $display("FAIL ignore_done k=%0d bcd=%h want k=13 0255", k, a_if.bcd);
        end
      end
      if (k > 13 && a_if.busy) begin
        checks++;
        errors++;
        $display("FAIL ignore_busy k=%0d busy=1 want 0", k);
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL ignore_count dones=%0d want 1", dones);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] b;
    logic o;
    int lat;
    int dones;
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.bin   = 12'd2047;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_p = 1'b1;
    #1;
    checks++;
    if ({a_if.busy, a_if.done, a_if.overflow} !== 3'b000 || a_if.bcd !== 16'h0) begin
      errors++;
      $display("FAIL midreset busy=%b done=%b ovf=%b bcd=%h want 0", a_if.busy,
               a_if.done, a_if.overflow, a_if.bcd);
    end
    @(negedge clk);
    @(negedge clk);
    reset_p = 1'b0;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (a_if.done || a_if.busy) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midreset_quiet activity=%0d want 0", dones);
    end
    convert_a(12'd321, b, o, lat);
    checks++;
    if (b !== 16'h0321 || o !== 1'b0 || lat != 13) begin
      errors++;
      $display("FAIL after_reset bcd=%h ovf=%b lat=%0d want 0321/0/13", b, o, lat);
    end
  endtask

  task automatic test_back_to_back();
    int edges[$];
    @(negedge clk);
    a_if.start = 1'b1;
    a_if.bin   = 12'd100;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (k == 39) a_if.start = 1'b0;
      if (a_if.done) begin
        edges.push_back(k);
        checks++;
        if (a_if.bcd !== 16'h0100) begin
          errors++;
          $display("FAIL b2b_value k=%0d bcd=%h want 0100", k, a_if.bcd);
        end
      end
    end
    checks++;
    if (edges.size() != 3) begin
      errors++;
      $display("FAIL b2b_count dones=%0d want 3", edges.size());
    end else begin
      checks++;
      if (edges[0] != 13 || edges[1] != 27 || edges[2] != 41) begin
        errors++;
        $display("FAIL b2b_spacing edges=%0d,%0d,%0d want 13,27,41",
                 edges[0], edges[1], edges[2]);
      end
    end
  endtask

  initial begin
    a_if.start = 1'b0;
    a_if.bin   = '0;
    b_if.start = 1'b0;
    b_if.bin   = '0;
    test_reset();
    test_timing();
    test_values();
    test_overflow();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
